dma_completion_tracker: RTL and testbench

Sits directly downstream of the DMA engine's write path. It pairs AXI-MM write responses (B channel) with the descriptors the engine has accepted. When every burst of a descriptor has been acknowledged, it pushes one completion record into a response FIFO that the CSR manager reads. It drives the response FIFO full/empty status, the aggregated response-error status, and the DMA interrupt request.

---
 rtl/dma_pkg.sv | 17 +
 rtl/dma_pending_queue.sv | 45 ++++
 rtl/ofs_plat_prim_fifo_bram.sv | 50 +++++
 rtl/dma_completion_tracker.sv | 147 ++++++++++++++
 tb/tb_dma_completion_tracker.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types for the DMA completion tracker
// DMA_COMPLETION_TIMESTAMP_EN adds a 32-bit cycle timestamp to each completion record.
package dma_pkg;

  localparam int DMA_COMPLETION_SEQ_W = 8;
  localparam logic [1:0] DMA_RESP_OKAY = 2'b00;

  typedef struct packed {
`ifdef DMA_COMPLETION_TIMESTAMP_EN
    logic [31:0]                     timestamp;
`endif
    logic [DMA_COMPLETION_SEQ_W-1:0] seq;
    logic                            err;
    logic [1:0]                      resp_enc;
  } t_dma_completion;

endpackage

// File: rtl/dma_pending_queue.sv
// rtl/dma_pending_queue.sv - register FIFO of accepted descriptors awaiting their B responses
module dma_pending_queue #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_not_full,
  output logic             o_not_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_not_full  = (r_count != (AW+1)'(DEPTH));
  assign o_not_empty = (r_count != '0);
  assign w_push      = i_push & o_not_full;
  assign w_pop       = i_pop & o_not_empty;
  assign o_head      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/ofs_plat_prim_fifo_bram.sv
// rtl/ofs_plat_prim_fifo_bram.sv - completion record FIFO with registered full/empty flags
module ofs_plat_prim_fifo_bram #(
  parameter int N_DATA_BITS = 11,
  parameter int N_ENTRIES   = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_DATA_BITS-1:0] enq_data,
  input  logic                   enq_en,
  output logic                   notFull,
  output logic [N_DATA_BITS-1:0] first,
  input  logic                   deq_en,
  output logic                   notEmpty
);
  localparam int AW = $clog2(N_ENTRIES);

  logic [N_DATA_BITS-1:0] r_mem [N_ENTRIES];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic [AW:0]            w_count_nxt;
  logic                   w_enq;
  logic                   w_deq;

  // A dequeue frees a slot in the same cycle, so a full FIFO still takes a push alongside a pop.
  assign w_deq       = deq_en & notEmpty;
  assign w_enq       = enq_en & (notFull | w_deq);
  assign w_count_nxt = r_count + (AW+1)'(w_enq) - (AW+1)'(w_deq);
  assign first       = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wr_ptr] <= enq_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      notFull  <= 1'b1;
      notEmpty <= 1'b0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count  <= w_count_nxt;
      notFull  <= (w_count_nxt != (AW+1)'(N_ENTRIES));
      notEmpty <= (w_count_nxt != '0);
    end
  end
endmodule

// File: rtl/dma_completion_tracker.sv
// rtl/dma_completion_tracker.sv - pairs B responses with pending descriptors and queues completion records
// DMA_COMPLETION_TIMESTAMP_EN stamps each record with a free-running cycle count.
module dma_completion_tracker
  import dma_pkg::*;
#(
  parameter int MAX_DESC_IN_FLIGHT = 32,
  parameter int RESP_FIFO_DEPTH    = 64,
  parameter int BURSTS_W           = 16
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                desc_valid,
  output logic                                desc_ready,
  input  logic [BURSTS_W-1:0]                 desc_num_bursts,
  input  logic                                desc_irq_en,
  input  logic                                bresp_valid,
  output logic                                bresp_ready,
  input  logic [1:0]                          bresp,
  output logic                                resp_valid,
  input  logic                                resp_rdack,
  output t_dma_completion                     resp_data,
  output logic                                resp_fifo_full,
  output logic                                resp_fifo_empty,
  output logic [$clog2(MAX_DESC_IN_FLIGHT):0] outstanding,
  output logic                                irq,
  input  logic                                irq_clear,
  output logic                                spurious_err
);
  localparam int SEQ_W  = DMA_COMPLETION_SEQ_W;
  localparam int PEND_W = BURSTS_W + 1 + SEQ_W;
  localparam int OUT_W  = $clog2(MAX_DESC_IN_FLIGHT) + 1;
  localparam int REC_W  = $bits(t_dma_completion);

  logic [SEQ_W-1:0]    r_seq;
  logic [BURSTS_W-1:0] r_beats_done;
  logic                r_err_seen;
  logic [1:0]          r_first_code;
  logic [OUT_W-1:0]    r_outstanding;
  logic                r_irq;
  logic                r_spurious;
  logic                w_desc_acc;
  logic                w_not_full;
  logic                w_not_empty;
  logic [PEND_W-1:0]   w_head;
  logic [BURSTS_W-1:0] w_head_bursts;
  logic                w_head_irq;
  logic [SEQ_W-1:0]    w_head_seq;
  logic                w_head_zero;
  logic                w_final_beat;
  logic                w_b_acc;
  logic                w_beat;
  logic                w_this_err;
  logic                w_done;
  logic                w_fifo_not_full;
  logic                w_fifo_not_empty;
  logic [REC_W-1:0]    w_fifo_first;
  t_dma_completion     w_rec;

  dma_pending_queue #(.DEPTH(MAX_DESC_IN_FLIGHT), .WIDTH(PEND_W)) u_pending (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_desc_acc),
    .i_data     ({desc_num_bursts, desc_irq_en, r_seq}),
    .i_pop      (w_done),
    .o_head     (w_head),
    .o_not_full (w_not_full),
    .o_not_empty(w_not_empty)
  );

  assign desc_ready = w_not_full;
  assign w_desc_acc = desc_valid & w_not_full;
  assign {w_head_bursts, w_head_irq, w_head_seq} = w_head;

  // A zero-burst head owns no B beats, so B traffic waits until it has retired.
  assign w_head_zero  = w_not_empty & (w_head_bursts == '0);
  assign w_final_beat = w_not_empty & ~w_head_zero & ((r_beats_done + BURSTS_W'(1)) == w_head_bursts);
  assign bresp_ready  = ~(resp_fifo_full & w_final_beat) & ~w_head_zero;
  assign w_b_acc      = bresp_valid & bresp_ready;
  assign w_beat       = w_b_acc & w_not_empty;
  assign w_this_err   = w_beat & (bresp != DMA_RESP_OKAY);
  assign w_done       = w_head_zero ? ~resp_fifo_full : (w_beat & w_final_beat);

`ifdef DMA_COMPLETION_TIMESTAMP_EN
  logic [31:0] r_timestamp;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_timestamp <= '0;
    else          r_timestamp <= r_timestamp + 32'd1;
  end
`endif

  always_comb begin
    w_rec          = '0;
    w_rec.seq      = w_head_seq;
    w_rec.err      = r_err_seen | w_this_err;
    w_rec.resp_enc = r_err_seen ? r_first_code : (w_this_err ? bresp : DMA_RESP_OKAY);
`ifdef DMA_COMPLETION_TIMESTAMP_EN
    w_rec.timestamp = r_timestamp;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seq         <= '0;
      r_beats_done  <= '0;
      r_err_seen    <= 1'b0;
      r_first_code  <= DMA_RESP_OKAY;
      r_outstanding <= '0;
      r_irq         <= 1'b0;
      r_spurious    <= 1'b0;
    end else begin
      if (w_desc_acc) r_seq <= r_seq + SEQ_W'(1);
      if (w_done) begin
        r_beats_done <= '0;
        r_err_seen   <= 1'b0;
        r_first_code <= DMA_RESP_OKAY;
      end else if (w_beat) begin
        r_beats_done <= r_beats_done + BURSTS_W'(1);
        r_err_seen   <= r_err_seen | w_this_err;
        if (w_this_err && !r_err_seen) r_first_code <= bresp;
      end
      if (w_desc_acc && !w_done)      r_outstanding <= r_outstanding + OUT_W'(1);
      else if (!w_desc_acc && w_done) r_outstanding <= r_outstanding - OUT_W'(1);
      if (w_b_acc && !w_not_empty) r_spurious <= 1'b1;
      if (w_done && w_head_irq) r_irq <= 1'b1;
      else if (irq_clear)       r_irq <= 1'b0;
    end
  end

  ofs_plat_prim_fifo_bram #(.N_DATA_BITS(REC_W), .N_ENTRIES(RESP_FIFO_DEPTH)) u_resp_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .enq_data(w_rec),
    .enq_en  (w_done),
    .notFull (w_fifo_not_full),
    .first   (w_fifo_first),
    .deq_en  (resp_rdack),
    .notEmpty(w_fifo_not_empty)
  );

  assign resp_fifo_full  = ~w_fifo_not_full;
  assign resp_fifo_empty = ~w_fifo_not_empty;
  assign resp_valid      = w_fifo_not_empty;
  assign resp_data       = w_fifo_not_empty ? t_dma_completion'(w_fifo_first) : '0;
  assign outstanding     = r_outstanding;
  assign irq             = r_irq;
  assign spurious_err    = r_spurious;
endmodule

// File: tb/tb_dma_completion_tracker.sv
// tb/tb_dma_completion_tracker.sv - directed scoreboard bench for dma_completion_tracker
module tb_dma_completion_tracker;
  import dma_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            desc_valid = 1'b0;
  logic            desc_ready;
  logic [15:0]     desc_num_bursts = '0;
  logic            desc_irq_en = 1'b0;
  logic            bresp_valid = 1'b0;
  logic            bresp_ready;
  logic [1:0]      bresp = 2'b00;
  logic            resp_valid;
  logic            resp_rdack = 1'b0;
  t_dma_completion resp_data;
  logic            resp_fifo_full;
  logic            resp_fifo_empty;
  logic [5:0]      outstanding;
  logic            irq;
  logic            irq_clear = 1'b0;
  logic            spurious_err;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  m_seq = '0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  dma_completion_tracker #(.MAX_DESC_IN_FLIGHT(32), .RESP_FIFO_DEPTH(64), .BURSTS_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_num_bursts(desc_num_bursts), .desc_irq_en(desc_irq_en),
    .bresp_valid(bresp_valid), .bresp_ready(bresp_ready), .bresp(bresp),
    .resp_valid(resp_valid), .resp_rdack(resp_rdack), .resp_data(resp_data),
    .resp_fifo_full(resp_fifo_full), .resp_fifo_empty(resp_fifo_empty),
    .outstanding(outstanding), .irq(irq), .irq_clear(irq_clear),
    .spurious_err(spurious_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    desc_valid = 0; bresp_valid = 0; resp_rdack = 0; irq_clear = 0;
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
    tick();
    m_seq = '0;
    exp_q.delete();
  endtask

  task automatic expect_rec(input logic [7:0] seq, input logic err, input logic [1:0] enc);
    exp_q.push_back({seq, err, enc});
  endtask

  task automatic send_desc(input logic [15:0] nb, input logic ie);
    int i = 0;
    desc_valid = 1; desc_num_bursts = nb; desc_irq_en = ie;
    while (!desc_ready && i < 200) begin tick(); i++; end
    if (i == 200) check("desc_timeout", desc_ready, 1);
    tick();
    desc_valid = 0;
    m_seq++;
  endtask

  task automatic send_b(input logic [1:0] code);
    int i = 0;
    bresp_valid = 1; bresp = code;
    while (!bresp_ready && i < 200) begin tick(); i++; end
    if (i == 200) check("b_timeout", bresp_ready, 1);
    tick();
    bresp_valid = 0;
  endtask

  task automatic pop_check(input string tag);
    int i = 0;
    logic [10:0] e;
    while (!resp_valid && i < 50) begin tick(); i++; end
    check({tag, "_valid"}, resp_valid, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7ff;
    check({tag, "_rec"}, {resp_data.seq, resp_data.err, resp_data.resp_enc}, e);
    resp_rdack = 1;
    tick();
    resp_rdack = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // reset state
    check("rst_desc_ready", desc_ready, 1);
    check("rst_bresp_ready", bresp_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_empty", resp_fifo_empty, 1);
    check("rst_full", resp_fifo_full, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_irq", irq, 0);
    check("rst_spurious", spurious_err, 0);
    check("rst_resp_data", resp_data, 0);

    // single 4-burst descriptor
    send_desc(16'd4, 1'b1);
    check("t1_outstanding1", outstanding, 1);
    for (int k = 0; k < 3; k++) send_b(2'b00);
    bresp_valid = 1; bresp = 2'b00;
    check("t1_no_early_rec", resp_valid, 0);
    expect_rec(8'd0, 1'b0, 2'b00);
    tick();
    bresp_valid = 0;
    check("t1_latency", resp_valid, 1);
    check("t1_irq", irq, 1);
    check("t1_outstanding0", outstanding, 0);
    pop_check("t1");
    irq_clear = 1; tick(); irq_clear = 0;
    check("t1_irq_cleared", irq, 0);

    // error aggregation across two descriptors
    do_reset();
    send_desc(16'd2, 1'b0);
    send_desc(16'd3, 1'b0);
    expect_rec(8'd0, 1'b1, 2'b10);
    expect_rec(8'd1, 1'b1, 2'b11);
    send_b(2'b00); send_b(2'b10);
    send_b(2'b00); send_b(2'b00); send_b(2'b11);
    pop_check("t2a");
    pop_check("t2b");

    // zero-burst descriptor between two 1-burst descriptors
    do_reset();
    send_desc(16'd1, 1'b0);
    send_desc(16'd0, 1'b0);
    send_desc(16'd1, 1'b0);
    expect_rec(8'd0, 1'b0, 2'b00);
    expect_rec(8'd1, 1'b0, 2'b00);
    send_b(2'b00);
    tick(); tick(); tick();
    check("t3_zero_no_b", outstanding, 1);
    expect_rec(8'd2, 1'b0, 2'b00);
    send_b(2'b00);
    pop_check("t3a"); pop_check("t3b"); pop_check("t3c");

    // response FIFO full back-pressure
    do_reset();
    for (int k = 0; k < 64; k++) begin
      expect_rec(m_seq, 1'b0, 2'b00);
      send_desc(16'd0, 1'b0);
    end
    tick(); tick();
    check("t4_full", resp_fifo_full, 1);
    send_desc(16'd1, 1'b0);
    bresp_valid = 1; bresp = 2'b00;
    check("t4_bready_stall", bresp_ready, 0);
    pop_check("t4_first");
    check("t4_bready_resume", bresp_ready, 1);
    expect_rec(8'd64, 1'b0, 2'b00);
    tick();
    bresp_valid = 0;
    check("t4_full_again", resp_fifo_full, 1);
    for (int k = 0; k < 64; k++) pop_check("t4_drain");
    check("t4_empty", resp_fifo_empty, 1);

    // pending queue full, then spurious B
    do_reset();
    for (int k = 0; k < 32; k++) send_desc(16'd1, 1'b0);
    check("t5_desc_ready0", desc_ready, 0);
    check("t5_outstanding32", outstanding, 32);
    expect_rec(8'd0, 1'b0, 2'b00);
    send_b(2'b00);
    check("t5_desc_ready1", desc_ready, 1);
    check("t5_outstanding31", outstanding, 31);
    for (int k = 1; k < 32; k++) begin
      expect_rec(8'(k), 1'b0, 2'b00);
      send_b(2'b00);
    end
    for (int k = 0; k < 32; k++) pop_check("t5_drain");
    check("t5_no_spurious", spurious_err, 0);
    send_b(2'b00);
    check("t5_spurious", spurious_err, 1);
    tick(); tick(); tick();
    check("t5_spurious_sticky", spurious_err, 1);
    check("t5_outstanding0", outstanding, 0);

    // irq set beats clear, then async reset mid-burst
    expect_rec(m_seq, 1'b0, 2'b00);
    send_desc(16'd1, 1'b1);
    bresp_valid = 1; bresp = 2'b00; irq_clear = 1;
    tick();
    bresp_valid = 0; irq_clear = 0;
    check("t6_irq_set_wins", irq, 1);
    pop_check("t6");
    irq_clear = 1; tick(); irq_clear = 0;
    check("t6_irq_clear", irq, 0);
    send_desc(16'd3, 1'b1);
    send_b(2'b01);
    bresp_valid = 1;
    check("t6_outstanding_pre", outstanding, 1);
    reset_n = 0;
    #1;
    check("t6_rst_outstanding", outstanding, 0);
    check("t6_rst_spurious", spurious_err, 0);
    check("t6_rst_desc_ready", desc_ready, 1);
    check("t6_rst_empty", resp_fifo_empty, 1);
    check("t6_rst_resp_valid", resp_valid, 0);
    check("t6_rst_irq", irq, 0);
    bresp_valid = 0;
    tick();
    reset_n = 1;
    tick();
    check("sb_leftover", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
